maze_tx_checker: RTL and testbench

Drives the serial maze-loading end of the maze-solver protocol and checks the solver's reply. A 15x15 maze is written row by row into local storage, then streamed one bit per cycle on maze/in_valid. The block then captures the solver's out_valid/out_x/out_y/maze_not_valid reply and verifies it against the stored maze, reporting pass/fail and an error code.

---
 rtl/maze_pkg.sv | 19 +
 rtl/maze_tx_checker_reply.sv | 56 +++++
 rtl/maze_tx_checker.sv | 113 +++++++++++
 tb/tb_maze_tx_checker.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared constants, coordinate, state and error types for the maze transmit/check block
package maze_pkg;
  localparam int N = 15;
  localparam int MAX_BEATS = 225;
  localparam int TIMEOUT_CYCLES = 1023;
  typedef logic [3:0] coord_t;
  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, REPORT} state_e;
  typedef enum logic [3:0] {
    OK        = 4'd0,
    TIMEOUT   = 4'd1,
    BLOCKED   = 4'd2,
    NOT_ADJ   = 4'd3,
    BAD_START = 4'd4,
    BAD_END   = 4'd5,
    MIXED     = 4'd6,
    OVERLEN   = 4'd7,
    BAD_MAZE  = 4'd8
  } err_e;
endpackage

// File: rtl/maze_tx_checker_reply.sv
// maze_reply_checker: per-beat reply checks with first-beat mode tracking and a sticky first error
module maze_reply_checker
  import maze_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   beat,
  input  logic   fin,
  input  logic   timeout,
  input  logic   over,
  input  logic   mnv,
  input  logic   wall,
  input  coord_t x,
  input  coord_t y,
  output err_e   err_nxt
);
  err_e err, ev;
  logic first, mode, path, blocked, adj;
  coord_t px, py, dx, dy;
  always_comb begin
    path = first ? !mnv : !mode;
    dx = x > px ? x - px : px - x;
    dy = y > py ? y - py : py - y;
    adj = 5'(dx) + 5'(dy) == 5'd1;
    blocked = x > 4'd14 || y > 4'd14 || wall;
    ev = timeout ? TIMEOUT
       : fin ? (!mode && (px != 4'd1 || py != 4'd1) ? BAD_END : OK)
       : !beat ? OK
       : over ? OVERLEN
       : !first && mnv != mode ? MIXED
       : !path ? OK
       : first && (x != 4'd13 || y != 4'd13) ? BAD_START
       : blocked ? BLOCKED
       : !first && !adj ? NOT_ADJ
       : OK;
    err_nxt = err != OK ? err : ev;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      first <= 1'b1;
      mode <= 1'b0;
      px <= '0;
      py <= '0;
      err <= OK;
    end else begin
      err <= err_nxt;
      if (beat) begin
        first <= 1'b0;
        mode <= first ? mnv : mode;
        px <= x;
        py <= y;
      end
    end
  end
endmodule

// File: rtl/maze_tx_checker.sv
// maze_tx_checker: streams a stored 15x15 maze and verifies the solver reply (MAZE_TX_BORDER_CHK_EN enables a border pre-check)
module maze_tx_checker
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_row,
  input  logic [14:0] cfg_data,
  input  logic        start,
  output logic        busy,
  output logic        maze,
  output logic        in_valid,
  input  logic        out_valid,
  input  logic        maze_not_valid,
  input  logic [3:0]  out_x,
  input  logic [3:0]  out_y,
  output logic        done,
  output logic        pass,
  output logic [7:0]  path_len,
  output logic [3:0]  err_code
);
  state_e state;
  logic [N*N-1:0] bits, bits_nxt;
  logic [9:0] cnt;
  logic bad_maze, wall, beat, fin, to, over;
  err_e err_nxt;
  always_comb begin
    bits_nxt = bits;
    if (cfg_we && cfg_row < 4'd15) bits_nxt[int'(cfg_row)*N +: N] = cfg_data;
  end
`ifdef MAZE_TX_BORDER_CHK_EN
  always_comb begin
    bad_maze = bits_nxt[N+1] | bits_nxt[13*N+13];
    for (int i = 0; i < N; i++)
      bad_maze = bad_maze | ~bits_nxt[i] | ~bits_nxt[N*(N-1)+i] | ~bits_nxt[N*i] | ~bits_nxt[N*i+N-1];
  end
`else
  assign bad_maze = 1'b0;
`endif
  assign wall = bits[8'(out_x) * 8'd15 + 8'(out_y)];
  assign beat = out_valid && (state == WAIT || state == RECV);
  assign fin = state == RECV && !out_valid;
  assign to = state == WAIT && !out_valid && cnt == 10'(TIMEOUT_CYCLES - 1);
  assign over = path_len == 8'(MAX_BEATS);
  maze_reply_checker u_chk (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE && start),
    .beat(beat),
    .fin(fin),
    .timeout(to),
    .over(over),
    .mnv(maze_not_valid),
    .wall(wall),
    .x(out_x),
    .y(out_y),
    .err_nxt(err_nxt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bits <= '0;
      cnt <= '0;
      busy <= 1'b0;
      maze <= 1'b0;
      in_valid <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      path_len <= '0;
      err_code <= '0;
    end else begin
      in_valid <= state == SEND;
      maze <= state == SEND && bits[cnt[7:0]];
      done <= 1'b0;
      case (state)
        IDLE: begin
          bits <= bits_nxt;
          if (start) begin
            state <= bad_maze ? REPORT : SEND;
            busy <= 1'b1;
            done <= bad_maze;
            cnt <= '0;
            path_len <= '0;
            pass <= 1'b0;
            err_code <= bad_maze ? BAD_MAZE : OK;
          end
        end
        SEND: begin
          state <= cnt == 10'(N*N-1) ? WAIT : SEND;
          cnt <= cnt == 10'(N*N-1) ? '0 : cnt + 10'd1;
        end
        WAIT, RECV: begin
          cnt <= cnt + 10'd1;
          if (beat) begin
            state <= RECV;
            path_len <= path_len + 8'(!over);
          end else if (fin || to) begin
            state <= REPORT;
            done <= 1'b1;
            pass <= err_nxt == OK;
            err_code <= err_nxt;
          end
        end
        REPORT: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maze_tx_checker.sv
// tb_maze_tx_checker: randomized self-checking bench against a reply-judging reference model
module tb_maze_tx_checker;
`ifdef MAZE_TX_BORDER_CHK_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif
  typedef struct packed {logic nv; logic [3:0] x; logic [3:0] y;} beat_t;
  logic clk = 1'b0;
  logic rst, cfg_we, start, out_valid, maze_not_valid;
  logic [3:0] cfg_row, out_x, out_y;
  logic [14:0] cfg_data;
  logic busy, maze, in_valid, done, pass;
  logic [7:0] path_len;
  logic [3:0] err_code;
  int checks = 0, failures = 0;
  bit m [15][15];
  beat_t rq[$];
  bit active, e_busy, e_iv, e_mz, e_done, e_hold, e_pass;
  int e_err, e_len;
  always #5 clk = ~clk;
  maze_tx_checker dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .start(start), .busy(busy), .maze(maze), .in_valid(in_valid),
    .out_valid(out_valid), .maze_not_valid(maze_not_valid), .out_x(out_x), .out_y(out_y),
    .done(done), .pass(pass), .path_len(path_len), .err_code(err_code)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (active) begin
    chk("busy", busy, e_busy);
    chk("in_valid", in_valid, e_iv);
    if (e_iv) chk("maze_bit", maze, e_mz);
    chk("done", done, e_done);
    if (e_hold) begin
      chk("pass", pass, e_pass);
      chk("err_code", err_code, e_err);
      chk("path_len", path_len, e_len);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int judge();
    int e = 0;
    if (rq.size() == 0) return 1;
    for (int i = 0; i < rq.size(); i++) begin
      int ev = 0;
      int dx = int'(rq[i].x) - (i > 0 ? int'(rq[i-1].x) : 0);
      int dy = int'(rq[i].y) - (i > 0 ? int'(rq[i-1].y) : 0);
      dx = dx < 0 ? -dx : dx;
      dy = dy < 0 ? -dy : dy;
      if (i >= 225) ev = 7;
      else if (rq[i].nv != rq[0].nv) ev = 6;
      else if (!rq[0].nv) begin
        if (i == 0 && (rq[i].x != 13 || rq[i].y != 13)) ev = 4;
        else if (rq[i].x > 14 || rq[i].y > 14 || m[rq[i].x][rq[i].y]) ev = 2;
        else if (i > 0 && dx + dy != 1) ev = 3;
      end
      if (e == 0) e = ev;
    end
    if (e == 0 && !rq[0].nv && (rq[rq.size()-1].x != 1 || rq[rq.size()-1].y != 1)) e = 5;
    return e;
  endfunction
  function automatic bit maze_bad();
    for (int i = 0; i < 15; i++)
      if (!m[0][i] || !m[14][i] || !m[i][0] || !m[i][14]) return 1'b1;
    return m[1][1] || m[13][13];
  endfunction
  task automatic wr(input logic [3:0] row, input logic [14:0] data);
    cfg_we = 1'b1;
    cfg_row = row;
    cfg_data = data;
    tick;
    cfg_we = 1'b0;
    if (row < 15) for (int c = 0; c < 15; c++) m[row][c] = data[c];
  endtask
  task automatic push(input bit nv, input int x, input int y);
    beat_t b;
    b.nv = nv;
    b.x = 4'(x);
    b.y = 4'(y);
    rq.push_back(b);
  endtask
  task automatic good_path();
    rq.delete();
    for (int c = 13; c >= 1; c--) push(1'b0, 13, c);
    for (int r = 12; r >= 1; r--) push(1'b0, r, 1);
  endtask
  task automatic rand_reply();
    int x = 13, y = 13, len = $urandom_range(1, 40);
    bit nv = $urandom_range(0, 3) == 0;
    rq.delete();
    if ($urandom_range(0, 3) == 0) begin
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
    end
    for (int i = 0; i < len; i++) begin
      push(nv ^ ($urandom_range(0, 31) == 0), x, y);
      case ($urandom_range(0, 3))
        0: x++;
        1: x--;
        2: y++;
        default: y--;
      endcase
      if ($urandom_range(0, 15) == 0) x = $urandom_range(0, 15);
      x = x < 0 ? 0 : (x > 15 ? 15 : x);
      y = y < 0 ? 0 : (y > 15 ? 15 : y);
    end
  endtask
  task automatic open_maze();
    for (int r = 0; r < 15; r++) wr(4'(r), (r == 0 || r == 14) ? 15'h7fff : 15'h4001);
  endtask
  task automatic rand_maze();
    for (int r = 0; r < 15; r++) begin
      logic [14:0] d = 15'($urandom) & 15'($urandom) & 15'($urandom);
      d = (r == 0 || r == 14) ? 15'h7fff : (d | 15'h4001);
      if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 14)] = 1'b0;
      wr(4'(r), d);
    end
  endtask
  task automatic run(input int d, input int abort_at, input bit sw, input logic [3:0] srow, input logic [14:0] sdata);
    int err, len, c0;
    bit bad;
    cfg_we = sw;
    cfg_row = srow;
    cfg_data = sdata;
    start = 1'b1;
    out_valid = 1'($urandom);
    tick;
    cfg_we = 1'b0;
    start = 1'b0;
    if (sw && srow < 15) for (int c = 0; c < 15; c++) m[srow][c] = sdata[c];
    err = judge();
    len = rq.size() > 225 ? 225 : rq.size();
    bad = BORDER_EN && maze_bad();
    e_busy = 1'b1;
    e_hold = 1'b0;
    e_done = 1'b0;
    e_iv = 1'b0;
    if (bad) begin
      e_done = 1'b1;
      e_hold = 1'b1;
      e_pass = 1'b0;
      e_err = 8;
      e_len = 0;
      out_valid = 1'b0;
      tick;
      e_done = 1'b0;
      e_busy = 1'b0;
      return;
    end
    for (int k = 0; k < 225; k++) begin
      out_valid = 1'($urandom);
      maze_not_valid = 1'($urandom);
      out_x = 4'($urandom);
      out_y = 4'($urandom);
      if (k == abort_at) begin
        rst = 1'b1;
        out_valid = 1'b0;
        tick;
        rst = 1'b0;
        e_busy = 1'b0;
        e_iv = 1'b0;
        e_done = 1'b0;
        e_hold = 1'b1;
        e_pass = 1'b0;
        e_err = 0;
        e_len = 0;
        for (int r = 0; r < 15; r++) for (int c = 0; c < 15; c++) m[r][c] = 1'b0;
        return;
      end
      tick;
      e_iv = 1'b1;
      e_mz = m[k/15][k%15];
    end
    out_valid = 1'b0;
    if (rq.size() == 0) begin
      for (int c = 226; c <= 1247; c++) begin
        tick;
        e_iv = 1'b0;
      end
    end else begin
      c0 = 225 + d;
      for (int c = 226; c <= c0; c++) begin
        tick;
        e_iv = 1'b0;
      end
      foreach (rq[i]) begin
        out_valid = 1'b1;
        maze_not_valid = rq[i].nv;
        out_x = rq[i].x;
        out_y = rq[i].y;
        tick;
        e_iv = 1'b0;
      end
      out_valid = 1'b0;
    end
    tick;
    e_iv = 1'b0;
    e_done = 1'b1;
    e_hold = 1'b1;
    e_err = err;
    e_pass = err == 0;
    e_len = len;
    tick;
    e_done = 1'b0;
    e_busy = 1'b0;
  endtask
  task automatic go(input int d);
    run(d, -1, 1'b0, 4'd0, 15'd0);
  endtask
  initial begin
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_row = '0;
    cfg_data = '0;
    start = 1'b0;
    out_valid = 1'b0;
    maze_not_valid = 1'b0;
    out_x = '0;
    out_y = '0;
    active = 1'b0;
    e_busy = 1'b0;
    e_iv = 1'b0;
    e_mz = 1'b0;
    e_done = 1'b0;
    e_hold = 1'b1;
    e_pass = 1'b0;
    e_err = 0;
    e_len = 0;
    tick;
    tick;
    rst = 1'b0;
    active = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_err", err_code, 0);
    open_maze();
    wr(4'd15, 15'h1234);
    good_path();
    chk("model_good", judge(), 0);
    run(3, -1, 1'b1, 4'd7, 15'h4021);
    chk("lit_good_pass", pass, 1);
    chk("lit_good_len", path_len, 25);
    chk("lit_good_err", err_code, 0);
    good_path();
    rq.delete(2);
    chk("model_jump", judge(), 3);
    go(5);
    chk("lit_jump_err", err_code, 3);
    chk("lit_jump_len", path_len, 24);
    wr(4'd5, 15'h4021);
    rq.delete();
    for (int r = 13; r >= 5; r--) push(1'b0, r, 13);
    for (int c = 12; c >= 1; c--) push(1'b0, 5, c);
    for (int r = 4; r >= 1; r--) push(1'b0, r, 1);
    go(2);
    chk("lit_wall_err", err_code, 2);
    wr(4'd5, 15'h4001);
    good_path();
    for (int i = 0; i < 12; i++) begin
      beat_t t = rq[i];
      rq[i] = rq[24-i];
      rq[24-i] = t;
    end
    go(7);
    chk("lit_start_err", err_code, 4);
    rq.delete();
    go(1);
    chk("lit_timeout_err", err_code, 1);
    chk("lit_timeout_pass", pass, 0);
    rq.delete();
    for (int i = 0; i < 3; i++) push(1'b1, $urandom_range(0, 15), $urandom_range(0, 15));
    go(4);
    chk("lit_nv_pass", pass, 1);
    chk("lit_nv_len", path_len, 3);
    rq.delete();
    push(1'b1, 3, 3);
    push(1'b1, 9, 2);
    push(1'b0, 13, 13);
    push(1'b1, 0, 0);
    go(1);
    chk("lit_mixed_err", err_code, 6);
    rq.delete();
    for (int i = 0; i < 230; i++) push(1'b1, i % 15, i % 7);
    go(2);
    chk("lit_over_err", err_code, 7);
    chk("lit_over_len", path_len, 225);
    good_path();
    void'(rq.pop_back());
    go(9);
    chk("lit_end_err", err_code, 5);
    wr(4'd0, 15'h7f7f);
    good_path();
    go(3);
`ifdef MAZE_TX_BORDER_CHK_EN
    chk("lit_border_err", err_code, 8);
`else
    chk("lit_noborder_err", err_code, 0);
`endif
    wr(4'd0, 15'h7fff);
    for (int t = 0; t < 12; t++) begin
      rand_maze();
      if ($urandom_range(0, 2) == 0) good_path();
      else rand_reply();
      go($urandom_range(1, 40));
    end
    open_maze();
    good_path();
    run(3, 100, 1'b0, 4'd0, 15'd0);
    chk("lit_abort_busy", busy, 0);
    chk("lit_abort_in_valid", in_valid, 0);
    go(2);
    tick;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
